// File: rtl/gb_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gb_bus_pkg
// Brief    : Shared widths and FSM state encoding for the memory-bus
//            access engine.
// Revision : 1.0 - initial release
// ============================================================================
package gb_bus_pkg;

  localparam int GB_ADDR_W = 16;
  localparam int GB_DATA_W = 8;

  // Shared phase counter; wide enough to hold the largest strobe timeout (255).
  localparam int GB_CNT_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } gb_state_e;

endpackage
`default_nettype wire

// File: rtl/gb_bus_access_if.sv
`default_nettype none
// ============================================================================
// Module   : gb_bus_access_if
// Brief    : Host-side request/response signals and memory-bus signals of
//            the access engine. master = engine, slave = host + memory.
// Revision : 1.0 - initial release
// ============================================================================
interface gb_bus_access_if;

  // Host side
  logic [gb_bus_pkg::GB_ADDR_W-1:0] addr_in;
  logic [gb_bus_pkg::GB_DATA_W-1:0] wdata_in;
  logic                             start;
  logic                             we;
  logic [gb_bus_pkg::GB_DATA_W-1:0] rdata_out;
  logic                             busy;
  logic                             done;
  logic                             timeout;

  // Memory-bus side
  logic [gb_bus_pkg::GB_ADDR_W-1:0] bus_addr;
  logic [gb_bus_pkg::GB_DATA_W-1:0] bus_wdata;
  logic                             bus_rd;
  logic                             bus_wr;
  logic [gb_bus_pkg::GB_DATA_W-1:0] bus_rdata;
  logic                             bus_wait;

  modport master (
    input  addr_in, wdata_in, start, we, bus_rdata, bus_wait,
    output bus_addr, bus_wdata, bus_rd, bus_wr, rdata_out, busy, done, timeout
  );

  modport slave (
    output addr_in, wdata_in, start, we, bus_rdata, bus_wait,
    input  bus_addr, bus_wdata, bus_rd, bus_wr, rdata_out, busy, done, timeout
  );

endinterface
`default_nettype wire

// File: rtl/gb_bus_cnt.sv
`default_nettype none
// ============================================================================
// Module   : gb_bus_cnt
// Brief    : Loadable down-counter with a zero flag. Load has priority over
//            decrement; decrement saturates at zero.
// Revision : 1.0 - initial release
// ============================================================================
module gb_bus_cnt #(
  parameter int WIDTH = 8
) (
  input  wire              clk,
  input  wire              reset,
  input  wire              load,
  input  wire  [WIDTH-1:0] load_val,
  input  wire              dec,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: reload, else step down until zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/gb_bus_access.sv
`default_nettype none
// ============================================================================
// Module   : gb_bus_access
// Brief    : Single-access memory-bus engine: latches a request, then runs
//            SETUP -> STROBE (wait-stretchable, with timeout) -> HOLD -> DONE.
// Revision : 1.0 - initial release
// ============================================================================
module gb_bus_access
  import gb_bus_pkg::*;
#(
  parameter int SETUP_CYC   = 1,
  parameter int HOLD_CYC    = 1,
  parameter int TIMEOUT_CYC = 255
) (
  input  wire             clk,
  input  wire             reset,
  gb_bus_access_if.master bus
);

  // Counter reload values: the counter holds "cycles remaining minus one",
  // so a phase ends on the cycle the zero flag is seen.
  localparam logic [GB_CNT_W-1:0] c_setup_ld =
    GB_CNT_W'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
  localparam logic [GB_CNT_W-1:0] c_hold_ld =
    GB_CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
  localparam logic [GB_CNT_W-1:0] c_timeout_ld =
    GB_CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  // Zero-length phases are skipped entirely.
  localparam gb_state_e c_after_start  = (SETUP_CYC > 0) ? ST_SETUP : ST_STROBE;
  localparam gb_state_e c_after_strobe = (HOLD_CYC > 0)  ? ST_HOLD  : ST_DONE;

  gb_state_e              state_q,   state_d;
  logic [GB_ADDR_W-1:0]   addr_q,    addr_d;
  logic [GB_DATA_W-1:0]   wdata_q,   wdata_d;
  logic                   we_q,      we_d;
  logic [GB_DATA_W-1:0]   rdata_q,   rdata_d;
  logic                   timeout_q, timeout_d;
  logic                   bus_rd_q,  bus_rd_d;
  logic                   bus_wr_q,  bus_wr_d;
  logic                   busy_q,    busy_d;
  logic                   done_q,    done_d;

  logic                   cnt_load;
  logic [GB_CNT_W-1:0]    cnt_val;
  logic                   cnt_dec;
  logic                   cnt_zero;

  gb_bus_cnt #(
    .WIDTH (GB_CNT_W)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Next-state, request latching, counter control and next output values.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    rdata_d   = rdata_q;
    timeout_d = timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          addr_d    = bus.addr_in;
          wdata_d   = bus.wdata_in;
          we_d      = bus.we;
          timeout_d = 1'b0;
          state_d   = c_after_start;
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          state_d = ST_STROBE;
        end
      end
      ST_STROBE: begin
        if (!bus.bus_wait) begin
          if (!we_q) begin
            rdata_d = bus.bus_rdata;
          end
          state_d = c_after_strobe;
        end else if (cnt_zero) begin
          // Target kept stretching for the whole budget: abandon the access.
          timeout_d = 1'b1;
          state_d   = c_after_strobe;
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Reload the shared counter on every state change.
    cnt_load = (state_d != state_q);
    cnt_dec  = !cnt_load;
    case (state_d)
      ST_SETUP:  cnt_val = c_setup_ld;
      ST_STROBE: cnt_val = c_timeout_ld;
      ST_HOLD:   cnt_val = c_hold_ld;
      default:   cnt_val = '0;
    endcase

    // Outputs are decoded from the next state so they register in step
    // with the state itself; we_d covers a direct IDLE -> STROBE entry.
    bus_rd_d = (state_d == ST_STROBE) && !we_d;
    bus_wr_d = (state_d == ST_STROBE) &&  we_d;
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
      bus_rd_q  <= 1'b0;
      bus_wr_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
      bus_rd_q  <= bus_rd_d;
      bus_wr_q  <= bus_wr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_rd    = bus_rd_q;
  assign bus.bus_wr    = bus_wr_q;
  assign bus.rdata_out = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_gb_bus_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_gb_bus_access
// Brief    : Self-checking bench for gb_bus_access with a transaction-level
//            timing model and directed plus randomized accesses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gb_bus_access;

  localparam int S  = 1;
  localparam int H  = 1;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset;

  gb_bus_access_if bif();

  gb_bus_access #(
    .SETUP_CYC   (S),
    .HOLD_CYC    (H),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: one accepted access is described by its acceptance cycle t0,
  // its strobe length L and whether it timed out; outputs follow by arithmetic.
  int          cyc     = 0;
  bit          m_have  = 1'b0;
  int          m_t0    = 0;
  int          m_L     = 1;
  int          m_w     = 0;
  bit          m_we    = 1'b0;
  bit          m_to    = 1'b0;
  logic [15:0] m_addr  = '0;
  logic [7:0]  m_wdata = '0;
  logic [7:0]  m_rd_old = '0;
  logic [7:0]  m_rd_new = '0;

  logic        exp_rd    = 1'b0;
  logic        exp_wr    = 1'b0;
  logic        exp_busy  = 1'b0;
  logic        exp_done  = 1'b0;
  logic        exp_to    = 1'b0;
  logic [15:0] exp_addr  = '0;
  logic [7:0]  exp_wdata = '0;
  logic [7:0]  exp_rdata = '0;

  int          plan_w   = 0;
  bit          rd_fixed = 1'b0;
  logic [7:0]  rd_val   = '0;
  bit          cmp_en   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] ex);
    n_checks++;
    if (got !== ex) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h cycle=%0d", nm, got, ex, cyc);
    end
  endtask

  task automatic model_step();
    int k;
    if (reset) begin
      m_have = 1'b0; m_addr = '0; m_wdata = '0; m_rd_old = '0; m_rd_new = '0;
      m_to = 1'b0; m_we = 1'b0; m_L = 1; m_w = 0;
      exp_rd = 1'b0; exp_wr = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
      exp_to = 1'b0; exp_addr = '0; exp_wdata = '0; exp_rdata = '0;
      return;
    end
    // A start is taken only while the engine is idle.
    if (bif.start && !exp_busy) begin
      m_rd_old = exp_rdata;
      m_have   = 1'b1;
      m_t0     = cyc;
      m_we     = bif.we;
      m_addr   = bif.addr_in;
      m_wdata  = bif.wdata_in;
      m_w      = plan_w;
      m_to     = (plan_w >= TO);
      m_L      = m_to ? TO : plan_w + 1;
    end
    if (m_have && !m_we && !m_to && cyc == m_t0 + S + m_L) m_rd_new = bif.bus_rdata;
    cyc++;
    k = m_have ? cyc - m_t0 : 0;
    exp_busy  = m_have && k >= 1 && k <= S + m_L + H + 1;
    exp_rd    = m_have && !m_we && k >= S + 1 && k <= S + m_L;
    exp_wr    = m_have &&  m_we && k >= S + 1 && k <= S + m_L;
    exp_done  = m_have && k == S + m_L + H + 1;
    exp_to    = m_have && m_to && k >= S + m_L + 1;
    exp_rdata = (m_have && !m_we && !m_to && k >= S + m_L + 1) ? m_rd_new : m_rd_old;
    exp_addr  = m_addr;
    exp_wdata = m_wdata;
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("bus_rd",    32'(bif.bus_rd),    32'(exp_rd));
        chk("bus_wr",    32'(bif.bus_wr),    32'(exp_wr));
        chk("busy",      32'(bif.busy),      32'(exp_busy));
        chk("done",      32'(bif.done),      32'(exp_done));
        chk("timeout",   32'(bif.timeout),   32'(exp_to));
        chk("rdata_out", 32'(bif.rdata_out), 32'(exp_rdata));
        chk("bus_addr",  32'(bif.bus_addr),  32'(exp_addr));
        chk("bus_wdata", 32'(bif.bus_wdata), 32'(exp_wdata));
        chk("rd_wr_excl", 32'(bif.bus_rd && bif.bus_wr), 32'(0));
      end
    end
  endtask

  // Memory-side stimulus: hold bus_wait high for the planned number of
  // strobe cycles of the access in flight, random elsewhere.
  task automatic drive_bus();
    if (m_have && cyc >= m_t0 + S + 1 && cyc <= m_t0 + S + m_L)
      bif.bus_wait = ((cyc - m_t0 - S) <= m_w);
    else
      bif.bus_wait = 1'($urandom_range(0, 1));
    bif.bus_rdata = rd_fixed ? rd_val : 8'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive_bus();
  endtask

  // Issue one access from an idle cycle and observe it up to the cycle after done.
  task automatic run_txn(input bit t_we, input logic [15:0] a, input logic [7:0] d,
                         input int w, input bit rude,
                         output int lat, output int sw, output int nd,
                         output logic [15:0] sa, output logic [7:0] swd, output logic to1);
    bif.we = t_we; bif.addr_in = a; bif.wdata_in = d; plan_w = w; bif.start = 1'b1;
    lat = -1; sw = 0; nd = 0; sa = '0; swd = '0; to1 = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      bif.start = 1'b0;
      if (i == 1) to1 = bif.timeout;
      if (bif.bus_rd || bif.bus_wr) begin
        sw++; sa = bif.bus_addr; swd = bif.bus_wdata;
      end
      if (bif.done) begin
        nd++;
        if (lat < 0) lat = i;
      end
      if (rude && i == 2) begin
        bif.start = 1'b1; bif.addr_in = 16'h1234;
      end
      if (rude && bif.done) bif.start = 1'b1;
      if (lat >= 0 && i > lat) break;
    end
  endtask

  int          lat, sw, nd;
  logic [15:0] sa;
  logic [7:0]  swd;
  logic        to1;
  bit          found;

  initial begin
    reset = 1'b1;
    bif.start = 1'b0; bif.we = 1'b0; bif.addr_in = '0; bif.wdata_in = '0;
    bif.bus_wait = 1'b0; bif.bus_rdata = '0;
    cmp_en = 1'b1;
    fork
      forever begin
        @(posedge clk or posedge reset);
        model_step();
      end
      compare_loop();
    join_none

    repeat (3) tick();
    chk("rst_busy",    32'(bif.busy),      32'(0));
    chk("rst_addr",    32'(bif.bus_addr),  32'(16'h0000));
    chk("rst_rdata",   32'(bif.rdata_out), 32'(8'h00));
    chk("rst_timeout", 32'(bif.timeout),   32'(0));
    chk("rst_strobe",  32'(bif.bus_rd | bif.bus_wr), 32'(0));

    // Read with defaults, issued on the first edge after reset release.
    reset = 1'b0;
    rd_fixed = 1'b1; rd_val = 8'h5A;
    run_txn(1'b0, 16'hC000, 8'h00, 0, 1'b0, lat, sw, nd, sa, swd, to1);
    chk("rd_lat",   32'(lat), 32'(4));
    chk("rd_width", 32'(sw),  32'(1));
    chk("rd_addr",  32'(sa),  32'(16'hC000));
    chk("rd_data",  32'(bif.rdata_out), 32'(8'h5A));

    // Write.
    rd_val = 8'hEE;
    run_txn(1'b1, 16'hFF40, 8'h91, 0, 1'b0, lat, sw, nd, sa, swd, to1);
    chk("wr_width", 32'(sw),  32'(1));
    chk("wr_addr",  32'(sa),  32'(16'hFF40));
    chk("wr_wdata", 32'(swd), 32'(8'h91));
    chk("wr_lat",   32'(lat), 32'(4));
    chk("wr_rdata_keep", 32'(bif.rdata_out), 32'(8'h5A));

    // Three wait states.
    rd_val = 8'h3C;
    run_txn(1'b0, 16'h8000, 8'h00, 3, 1'b0, lat, sw, nd, sa, swd, to1);
    chk("ws_width",   32'(sw),  32'(4));
    chk("ws_lat",     32'(lat), 32'(7));
    chk("ws_timeout", 32'(bif.timeout), 32'(0));
    chk("ws_rdata",   32'(bif.rdata_out), 32'(8'h3C));

    // Wait held past the budget.
    rd_val = 8'hEE;
    run_txn(1'b0, 16'h8001, 8'h00, 20, 1'b0, lat, sw, nd, sa, swd, to1);
    chk("to_width", 32'(sw),  32'(8));
    chk("to_lat",   32'(lat), 32'(11));
    chk("to_flag",  32'(bif.timeout), 32'(1));
    chk("to_rdata", 32'(bif.rdata_out), 32'(8'h3C));
    rd_val = 8'h44;
    run_txn(1'b0, 16'h8002, 8'h00, 0, 1'b0, lat, sw, nd, sa, swd, to1);
    chk("to_clear", 32'(to1), 32'(0));
    chk("to_next_rdata", 32'(bif.rdata_out), 32'(8'h44));

    // Extra starts and address change mid-access.
    run_txn(1'b0, 16'hABCD, 8'h00, 1, 1'b1, lat, sw, nd, sa, swd, to1);
    chk("rude_done_cnt", 32'(nd), 32'(1));
    chk("rude_addr",     32'(sa), 32'(16'hABCD));
    chk("rude_hold",     32'(bif.bus_addr), 32'(16'hABCD));
    chk("rude_lat",      32'(lat), 32'(5));

    // Reset while the strobe is active.
    tick();
    plan_w = 5; bif.we = 1'b0; bif.addr_in = 16'h5555; bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (bif.bus_rd) found = 1'b1;
    end
    chk("mid_strobe_seen", 32'(found), 32'(1));
    reset = 1'b1;
    #1;
    chk("mid_rst_rd",   32'(bif.bus_rd), 32'(0));
    chk("mid_rst_busy", 32'(bif.busy),   32'(0));
    nd = 0;
    repeat (3) begin
      tick();
      if (bif.done) nd++;
    end
    chk("mid_rst_nodone", 32'(nd), 32'(0));
    reset = 1'b0;
    rd_val = 8'h77;
    run_txn(1'b0, 16'h2468, 8'h00, 0, 1'b0, lat, sw, nd, sa, swd, to1);
    chk("post_rst_lat",   32'(lat), 32'(4));
    chk("post_rst_rdata", 32'(bif.rdata_out), 32'(8'h77));

    // Randomized accesses, some running into the timeout.
    rd_fixed = 1'b0;
    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(0, 3)) tick();
      run_txn(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom),
              int'($urandom_range(0, 10)), 1'($urandom_range(0, 1)),
              lat, sw, nd, sa, swd, to1);
      chk("rand_done_cnt", 32'(nd), 32'(1));
    end

    tick();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
